led_pwm_bank: RTL and testbench
===============================

LED_PWM_BANK -- requirements
Module: led_pwm_bank

Interface
REQ-001 SHALL have parameter CHANNELS, default 3: number of independent LED channels (1..16).
REQ-002 SHALL have parameter PWM_W, default 8: PWM and brightness width, so MAX = 2^PWM_W-1.
REQ-003 SHALL have parameter SPEED_W, default 16: width of each channel's prescaler reload.
REQ-004 SHALL have port clk, input, 1 bit: single clock; every register is clocked on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port enable, input, 1 bit: global run; when low, all counters hold and every led bit is 0.
REQ-007 SHALL have port speed, input, CHANNELS*SPEED_W bits: per-channel prescaler reload; channel i uses slice [i*SPEED_W +: SPEED_W].
REQ-008 SHALL have port mode, input, CHANNELS*2 bits: per-channel mode, 0=OFF, 1=ON, 2=BLINK, 3=BREATHE.
REQ-009 SHALL have port led, output, CHANNELS bits: registered LED drive, active-high.

Function
REQ-010 SHALL keep one shared free-running PWM_W-bit counter pwm_cnt that increments whenever enable=1 and wraps from MAX to 0.
REQ-011 SHALL give each channel a prescaler presc that asserts tick and reloads to 0 when presc >= speed_i, and otherwise increments; speed_i=0 therefore ticks every enabled cycle.
REQ-012 SHALL, when speed_i drops below the current presc value, tick on the next enabled cycle and then reload to 0 (no wrap-around through 2^SPEED_W).
REQ-013 SHALL, in BREATHE, run a two-state FSM (UP, DOWN) on tick: UP increments level; UP at MAX goes to DOWN with level held; DOWN decrements level; DOWN at 0 goes to UP with level held.
REQ-014 SHALL, in BLINK, toggle a per-channel blink bit on each tick and set duty to MAX when blink=1, else 0.
REQ-015 SHALL set duty to 0 in OFF; ON SHALL force led_i=1 regardless of pwm_cnt.
REQ-016 SHALL register led_i <= (duty_i > pwm_cnt) with a latency of one clock from pwm_cnt/duty to led.
REQ-017 SHALL, on any change of mode_i (detected against a registered copy), clear that channel's presc, level and blink and set its FSM to UP on the following cycle; other channels SHALL be unaffected.
REQ-018 SHALL, while enable=0, freeze pwm_cnt, presc, level, FSM and blink, drive led=0, and resume from the frozen values when enable returns to 1.

Reset
REQ-019 SHALL, while rst=0, asynchronously force pwm_cnt=0, presc=0, level=0, blink=0, FSM=UP, registered mode copy=0 (OFF) and led=0.
REQ-020 SHALL leave reset synchronously on the first clk edge after rst rises; a reset asserted mid-ramp SHALL discard all ramp state.

Configuration
REQ-021 SHALL, with macro LED_PWM_BANK_GAMMA_EN defined, compute BREATHE duty as the upper PWM_W bits of level*level (2*PWM_W-bit product).
REQ-022 SHALL, without LED_PWM_BANK_GAMMA_EN, compute BREATHE duty = level (linear); BLINK, ON and OFF SHALL be identical in both builds.

Structure
REQ-023 SHALL place the mode encoding constants (MODE_OFF, MODE_ON, MODE_BLINK, MODE_BREATHE) and the FSM state typedef in shared package led_pkg.
REQ-024 SHALL implement the prescaler, FSM, blink and duty logic in sub-module led_channel, instantiated CHANNELS times by a generate loop; pwm_cnt and the led compare registers SHALL live in led_pwm_bank.

Verification (PWM_W=4, SPEED_W=4, CHANNELS=3 unless stated)
REQ-025 SHALL check reset: hold rst=0 for 5 cycles with mode=BREATHE and enable=1 -> led=0, and pwm_cnt=0 at the first edge after release.
REQ-026 SHALL check breathe: ch0 BREATHE, speed=0, gamma off -> level sequence 0,1..15,15,14..0,0,1 on successive ticks; duty 8 gives led high for 8 of 16 cycles.
REQ-027 SHALL check blink and prescaler: ch1 BLINK, speed=3 -> led toggles between all-on and all-off every 4 cycles; changing speed from 9 to 2 while presc=7 -> tick on the next cycle.
REQ-028 SHALL check mode change: switch ch2 from BREATHE at level 10 to BLINK -> ch2 state cleared next cycle, while ch0 and ch1 levels stay unchanged.
REQ-029 SHALL check enable: deassert for 20 cycles at level 6 -> led=0 throughout, and level=6 with pwm_cnt unchanged on resume.
REQ-030 SHALL check gamma build: level=8 -> duty=4; level=15 -> duty=14; level=3 -> duty=0.

Source files
------------

// File: rtl/led_pkg.sv
// Shared encodings for the LED PWM bank: channel mode codes and the
// breathe direction state.
package led_pkg;

  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_ON      = 2'd1;
  localparam logic [1:0] MODE_BLINK   = 2'd2;
  localparam logic [1:0] MODE_BREATHE = 2'd3;

  typedef enum logic {
    ST_UP   = 1'b0,
    ST_DOWN = 1'b1
  } breathe_st_e;

endpackage

// File: rtl/led_channel.sv
// One LED channel: prescaler, breathe up/down FSM, blink toggle and duty
// select. Optional macro LED_PWM_BANK_GAMMA_EN squares the breathe level
// for a perceptually smoother ramp.
module led_channel
  import led_pkg::*;
#(
  parameter int PWM_W   = 8,
  parameter int SPEED_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [SPEED_W-1:0] speed,
  input  logic [1:0]         mode,
  output logic [PWM_W-1:0]   duty,
  output logic               force_on
);

  localparam logic [PWM_W-1:0] MAX = '1;

  logic [SPEED_W-1:0] presc;
  logic [PWM_W-1:0]   level;
  logic               blink;
  breathe_st_e        st;
  logic [1:0]         mode_q;
  logic               tick;

  // ">=" rather than "==" so a speed lowered below presc ticks at once
  // instead of wrapping through the full prescaler range.
  assign tick = (presc >= speed);

  // Channel state: frozen while disabled, cleared one cycle after a mode change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc  <= '0;
      level  <= '0;
      blink  <= 1'b0;
      st     <= ST_UP;
      mode_q <= MODE_OFF;
    end else if (enable) begin
      mode_q <= mode;
      if (mode != mode_q) begin
        presc <= '0;
        level <= '0;
        blink <= 1'b0;
        st    <= ST_UP;
      end else begin
        presc <= tick ? '0 : presc + 1'b1;
        if (tick) begin
          if (mode_q == MODE_BLINK) blink <= ~blink;
          if (mode_q == MODE_BREATHE) begin
            case (st)
              ST_UP:   if (level == MAX) st <= ST_DOWN; else level <= level + 1'b1;
              ST_DOWN: if (level == '0)  st <= ST_UP;   else level <= level - 1'b1;
              default: st <= ST_UP;
            endcase
          end
        end
      end
    end
  end

`ifdef LED_PWM_BANK_GAMMA_EN
  logic [2*PWM_W-1:0] level_sq;
  assign level_sq = level * level;
`endif

  // Duty select from the registered mode so it always matches channel state.
  always_comb begin
    duty     = '0;
    force_on = 1'b0;
    case (mode_q)
      MODE_ON:      force_on = 1'b1;
      MODE_BLINK:   duty = blink ? MAX : '0;
`ifdef LED_PWM_BANK_GAMMA_EN
      MODE_BREATHE: duty = level_sq[2*PWM_W-1:PWM_W];
`else
      MODE_BREATHE: duty = level;
`endif
      default:      duty = '0;
    endcase
  end

endmodule

// File: rtl/led_pwm_bank.sv
// Bank of CHANNELS LED drivers sharing one free-running PWM counter.
// Define LED_PWM_BANK_GAMMA_EN for squared (gamma) breathe brightness.
module led_pwm_bank
  import led_pkg::*;
#(
  parameter int CHANNELS = 3,
  parameter int PWM_W    = 8,
  parameter int SPEED_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [CHANNELS*SPEED_W-1:0] speed,
  input  logic [CHANNELS*2-1:0]   mode,
  output logic [CHANNELS-1:0]     led
);

  logic [PWM_W-1:0]                 pwm_cnt;
  logic [CHANNELS-1:0][PWM_W-1:0]   duty;
  logic [CHANNELS-1:0]              force_on;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    led_channel #(
      .PWM_W  (PWM_W),
      .SPEED_W(SPEED_W)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .enable  (enable),
      .speed   (speed[i*SPEED_W +: SPEED_W]),
      .mode    (mode[i*2 +: 2]),
      .duty    (duty[i]),
      .force_on(force_on[i])
    );
  end

  // Shared PWM counter and registered duty-vs-counter compare per channel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm_cnt <= '0;
      led     <= '0;
    end else begin
      if (enable) pwm_cnt <= pwm_cnt + 1'b1;
      for (int i = 0; i < CHANNELS; i++)
        led[i] <= enable & (force_on[i] | (duty[i] > pwm_cnt));
    end
  end

endmodule

// File: tb/tb_led_pwm_bank.sv
// Directed bench for led_pwm_bank (CHANNELS=3, PWM_W=4, SPEED_W=4).
module tb_led_pwm_bank;

  localparam int CH = 3;
  localparam int PW = 4;
  localparam int SW = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             enable = 1'b0;
  logic [CH*SW-1:0] speed = '0;
  logic [CH*2-1:0]  mode = '0;
  logic [CH-1:0]    led;

  int checks = 0;
  int errors = 0;
  int seq [34];

  always #5 clk = ~clk;

  led_pwm_bank #(.CHANNELS(CH), .PWM_W(PW), .SPEED_W(SW)) dut (
    .clk   (clk),
    .rst   (rst),
    .enable(enable),
    .speed (speed),
    .mode  (mode),
    .led   (led)
  );

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int gam(input int l);
`ifdef LED_PWM_BANK_GAMMA_EN
    return (l * l) >> PW;
`else
    return l;
`endif
  endfunction

  // Assert reset (discarding any ramp in progress), load inputs, release.
  task automatic start(input logic [CH*2-1:0] m, input logic [CH*SW-1:0] s);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("async_rst_level0", int'(dut.g_ch[0].u_ch.level), 0);
    chk("async_rst_led", int'(led), 0);
    mode   = m;
    speed  = s;
    enable = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_led", int'(led), 0);
    chk("rst_pwm_cnt", int'(dut.pwm_cnt), 0);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int hi;
    int exp;
    for (int i = 0; i < 16; i++) seq[i] = i;
    for (int i = 0; i < 16; i++) seq[16+i] = 15 - i;
    seq[32] = 0;
    seq[33] = 1;

    // Breathe ramp on ch0; ch1 parked at level 8 to measure duty.
    start(6'b111111, 12'h000);
    hi = 0;
    for (int e = 1; e <= 34; e++) begin
      @(negedge clk);
      chk($sformatf("breathe_lvl_e%0d", e), int'(dut.g_ch[0].u_ch.level), seq[e-1]);
      chk($sformatf("breathe_duty_e%0d", e), int'(dut.g_ch[0].u_ch.duty), gam(seq[e-1]));
      if (e == 1) chk("pwm_after_first_edge", int'(dut.pwm_cnt), 1);
      if (e == 9) speed[1*SW +: SW] = 4'd15;
      if (e >= 10 && e <= 25) hi += int'(led[1]);
    end
    chk("level8_high_cycles", hi, gam(8));

    // Blink on ch1 with speed 3: blink flips every 4 cycles.
    start(6'b001000, 12'h030);
    for (int e = 1; e <= 17; e++) begin
      @(negedge clk);
      if (e >= 6) begin
        exp = ((((e - 6) / 4) % 2) == 0 && (15 > ((e - 1) % 16))) ? 2 : 0;
        chk($sformatf("blink_led_e%0d", e), int'(led), exp);
      end
    end

    // Speed dropped below current prescaler value ticks immediately.
    start(6'b001000, 12'h090);
    repeat (8) @(negedge clk);
    chk("presc_before_drop", int'(dut.g_ch[1].u_ch.presc), 7);
    chk("blink_before_drop", int'(dut.g_ch[1].u_ch.blink), 0);
    speed = 12'h020;
    @(negedge clk);
    chk("blink_after_drop", int'(dut.g_ch[1].u_ch.blink), 1);
    chk("presc_after_drop", int'(dut.g_ch[1].u_ch.presc), 0);

    // Mode change on ch2 at level 10 clears only ch2.
    start(6'b111111, 12'h000);
    repeat (11) @(negedge clk);
    chk("ch2_level_before", int'(dut.g_ch[2].u_ch.level), 10);
    mode[5:4] = 2'b10;
    speed     = 12'h0FF;
    @(negedge clk);
    chk("ch2_level_cleared", int'(dut.g_ch[2].u_ch.level), 0);
    chk("ch2_blink_cleared", int'(dut.g_ch[2].u_ch.blink), 0);
    chk("ch2_presc_cleared", int'(dut.g_ch[2].u_ch.presc), 0);
    chk("ch2_state_up", int'(dut.g_ch[2].u_ch.st), 0);
    chk("ch0_level_kept", int'(dut.g_ch[0].u_ch.level), 10);
    chk("ch1_level_kept", int'(dut.g_ch[1].u_ch.level), 10);

    // Enable low for 20 cycles at level 6: outputs dark, state frozen.
    start(6'b000011, 12'h000);
    repeat (7) @(negedge clk);
    chk("en_level_before", int'(dut.g_ch[0].u_ch.level), 6);
    enable = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk($sformatf("en_off_led_c%0d", c), int'(led), 0);
    end
    chk("en_level_frozen", int'(dut.g_ch[0].u_ch.level), 6);
    chk("en_pwm_frozen", int'(dut.pwm_cnt), 7);
    enable = 1'b1;
    @(negedge clk);
    chk("en_level_resumed", int'(dut.g_ch[0].u_ch.level), 7);
    chk("en_pwm_resumed", int'(dut.pwm_cnt), 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
